// File: rtl/inst_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_cache_if
//  Description : Fetch and memory handshake bundle for the instruction cache.
//                The slave modport is the cache's view; the master modport is
//                the view of the fetcher plus memory controller that surround
//                it.
//                Fetcher side : pc, start_fetch -> fetch_ready, inst, inst_addr
//                Memory side  : mem_req, mem_addr -> mem_byte_valid, mem_byte
//  Revision    : 1.0  initial release
// ============================================================================
interface inst_cache_if;
    logic [31:0] pc;
    logic        start_fetch;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_byte_valid;
    logic [7:0]  mem_byte;

    modport slave (
        input  pc,
        input  start_fetch,
        output fetch_ready,
        output inst,
        output inst_addr,
        output mem_req,
        output mem_addr,
        input  mem_byte_valid,
        input  mem_byte
    );

    modport master (
        output pc,
        output start_fetch,
        input  fetch_ready,
        input  inst,
        input  inst_addr,
        input  mem_req,
        input  mem_addr,
        output mem_byte_valid,
        output mem_byte
    );
endinterface
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
//  Module      : inst_cache
//  Description : Direct-mapped, read-only instruction cache with one 32-bit
//                word per line. A hit answers one cycle after the request is
//                sampled; a miss fetches the word one byte at a time from the
//                memory controller, fills the line and then answers.
//  Ports       : clk_in        system clock
//                rst_in        synchronous active-high reset
//                rdy_in        global ready; low freezes every register
//                rob_clear_up  pipeline flush; aborts the current request
//                bus           inst_cache_if.slave (fetch + memory handshake)
//  Revision    : 1.0  initial release
// ============================================================================
module inst_cache #(
    parameter int INDEX_BITS = 6
) (
    input  wire logic       clk_in,
    input  wire logic       rst_in,
    input  wire logic       rdy_in,
    input  wire logic       rob_clear_up,
    inst_cache_if.slave     bus
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MISS = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES];

    logic [31:0]           r_req_addr;
    logic [1:0]            r_cnt;
    logic [7:0]            r_fill [4];

    logic                  r_fetch_ready;
    logic [31:0]           r_inst;
    logic [31:0]           r_inst_addr;
    logic                  r_mem_req;
    logic [31:0]           r_mem_addr;

    // Lookup uses the live pc so a hit can answer on the sampling edge.
    logic [INDEX_BITS-1:0] w_pc_index;
    logic [TAG_BITS-1:0]   w_pc_tag;
    logic                  w_hit;

    // Fill bookkeeping works from the latched request address.
    logic [INDEX_BITS-1:0] w_req_index;
    logic [TAG_BITS-1:0]   w_req_tag;
    logic [31:0]           w_base;
    logic [31:0]           w_fill_word;
    logic                  w_byte_accept;
    logic                  w_fill_done;

    assign w_pc_index  = bus.pc[INDEX_BITS+1:2];
    assign w_pc_tag    = bus.pc[31:INDEX_BITS+2];
    assign w_hit       = r_valid[w_pc_index] && (r_tag[w_pc_index] == w_pc_tag);

    assign w_req_index = r_req_addr[INDEX_BITS+1:2];
    assign w_req_tag   = r_req_addr[31:INDEX_BITS+2];
    assign w_base      = {r_req_addr[31:2], 2'b00};

    // The last byte goes straight from the bus into the word, so the line
    // and the response are both produced on the edge that accepts it.
    assign w_fill_word = {bus.mem_byte, r_fill[2], r_fill[1], r_fill[0]};

    // A byte counts only when nothing of higher priority owns the edge.
    assign w_byte_accept = !rst_in && rdy_in && !rob_clear_up &&
                           (r_state == S_MISS) && bus.mem_byte_valid;
    assign w_fill_done   = w_byte_accept && (r_cnt == 2'd3);

    // ------------------------------------------------------------------
    // Line storage and fill buffer: no reset needed, validity is tracked
    // separately in r_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_byte_accept) begin
            r_fill[r_cnt] <= bus.mem_byte;
        end
        if (w_fill_done) begin
            r_tag[w_req_index]  <= w_req_tag;
            r_data[w_req_index] <= w_fill_word;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_req_addr    <= 32'd0;
            r_cnt         <= 2'd0;
            r_fetch_ready <= 1'b0;
            r_inst        <= 32'd0;
            r_inst_addr   <= 32'd0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'd0;
        end else if (!rdy_in) begin
            // Global stall: every register holds.
        end else if (rob_clear_up) begin
            // Abort: any partial fill is simply forgotten; valid bits stay.
            r_state       <= S_IDLE;
            r_fetch_ready <= 1'b0;
            r_mem_req     <= 1'b0;
            r_cnt         <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_fetch) begin
                        r_req_addr <= bus.pc;
                        if (w_hit) begin
                            r_fetch_ready <= 1'b1;
                            r_inst        <= r_data[w_pc_index];
                            r_inst_addr   <= bus.pc;
                            r_state       <= S_RESP;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {bus.pc[31:2], 2'b00};
                            r_cnt      <= 2'd0;
                            r_state    <= S_MISS;
                        end
                    end
                end

                S_MISS: begin
                    if (bus.mem_byte_valid) begin
                        r_cnt      <= r_cnt + 2'd1;
                        r_mem_addr <= w_base + {30'd0, r_cnt} + 32'd1;
                        if (r_cnt == 2'd3) begin
                            r_valid[w_req_index] <= 1'b1;
                            r_mem_req            <= 1'b0;
                            r_fetch_ready        <= 1'b1;
                            r_inst               <= w_fill_word;
                            r_inst_addr          <= r_req_addr;
                            r_state              <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    // start_fetch is still high here and is deliberately
                    // ignored; the fetcher drops it after seeing the pulse.
                    r_fetch_ready <= 1'b0;
                    r_state       <= S_IDLE;
                end

                default: begin
                    r_fetch_ready <= 1'b0;
                    r_mem_req     <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_ready = r_fetch_ready;
    assign bus.inst        = r_inst;
    assign bus.inst_addr   = r_inst_addr;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_cache
//  Description : Directed self-checking bench for inst_cache. Inputs change
//                and outputs are sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_cache;

    logic clk;
    logic rst;
    logic rdy;
    logic rob_clear;

    int n_total = 0;
    int n_bad   = 0;

    inst_cache_if bus ();

    inst_cache #(
        .INDEX_BITS (6)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .rob_clear_up (rob_clear),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic give_byte(input logic [7:0] b);
        bus.mem_byte_valid = 1'b1;
        bus.mem_byte       = b;
        @(negedge clk);
        bus.mem_byte_valid = 1'b0;
    endtask

    // Request a word that must hit: pulse one cycle after the sample.
    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] word, input string name);
        bus.pc          = a;
        bus.start_fetch = 1'b1;
        @(negedge clk);
        check({name, " ready"}, {31'd0, bus.fetch_ready}, 32'd1);
        check({name, " inst"}, bus.inst, word);
        check({name, " inst_addr"}, bus.inst_addr, a);
        check({name, " no mem_req"}, {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        check({name, " ready drop"}, {31'd0, bus.fetch_ready}, 32'd0);
        bus.start_fetch = 1'b0;
        @(negedge clk);
        check({name, " no repeat"}, {31'd0, bus.fetch_ready}, 32'd0);
    endtask

    // Request a word that must miss; memory answers after gap idle cycles.
    task automatic fetch_miss(input logic [31:0] a, input logic [31:0] word,
                              input int gap, input string name);
        logic [31:0] w;
        w               = word;
        bus.pc          = a;
        bus.start_fetch = 1'b1;
        @(negedge clk);
        check({name, " mem_req"}, {31'd0, bus.mem_req}, 32'd1);
        check({name, " mem_addr0"}, bus.mem_addr, a);
        check({name, " no early ready"}, {31'd0, bus.fetch_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check({name, " gap addr"}, bus.mem_addr, a + 32'(i));
            end
            give_byte(w[8*i +: 8]);
            if (i < 3) begin
                check({name, " step addr"}, bus.mem_addr, a + 32'(i) + 32'd1);
                check({name, " req held"}, {31'd0, bus.mem_req}, 32'd1);
                check({name, " ready low"}, {31'd0, bus.fetch_ready}, 32'd0);
            end
        end
        check({name, " req drop"}, {31'd0, bus.mem_req}, 32'd0);
        check({name, " ready"}, {31'd0, bus.fetch_ready}, 32'd1);
        check({name, " inst"}, bus.inst, word);
        check({name, " inst_addr"}, bus.inst_addr, a);
        @(negedge clk);
        check({name, " ready drop"}, {31'd0, bus.fetch_ready}, 32'd0);
        check({name, " inst hold"}, bus.inst, word);
        bus.start_fetch = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst                = 1'b1;
        rdy                = 1'b1;
        rob_clear          = 1'b0;
        bus.pc             = 32'd0;
        bus.start_fetch    = 1'b0;
        bus.mem_byte_valid = 1'b0;
        bus.mem_byte       = 8'd0;
        repeat (2) @(negedge clk);
        check("rst ready", {31'd0, bus.fetch_ready}, 32'd0);
        check("rst inst", bus.inst, 32'd0);
        check("rst inst_addr", bus.inst_addr, 32'd0);
        check("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss, hit, then a conflict pair sharing index 4.
        fetch_miss(32'h0000_0010, 32'h0010_0513, 2, "cold");
        fetch_hit (32'h0000_0010, 32'h0010_0513, "hit");
        fetch_miss(32'h0000_0110, 32'h0020_0093, 1, "conf_b");
        fetch_miss(32'h0000_0010, 32'h0010_0513, 0, "conf_a");

        // Flush after two bytes; a byte offered in the flush cycle is dropped.
        bus.pc          = 32'h0000_0020;
        bus.start_fetch = 1'b1;
        @(negedge clk);
        check("flush addr0", bus.mem_addr, 32'h20);
        give_byte(8'h01);
        give_byte(8'h02);
        rob_clear          = 1'b1;
        bus.start_fetch    = 1'b0;
        bus.mem_byte_valid = 1'b1;
        bus.mem_byte       = 8'h03;
        @(negedge clk);
        rob_clear          = 1'b0;
        bus.mem_byte_valid = 1'b0;
        check("flush req off", {31'd0, bus.mem_req}, 32'd0);
        check("flush no ready", {31'd0, bus.fetch_ready}, 32'd0);
        check("flush addr hold", bus.mem_addr, 32'h22);
        repeat (2) begin
            @(negedge clk);
            check("flush quiet", {31'd0, bus.fetch_ready}, 32'd0);
        end
        fetch_miss(32'h0000_0020, 32'h0403_0201, 1, "refill");

        // Flush in the same cycle a hit is sampled: no pulse, then served.
        bus.pc          = 32'h0000_0020;
        bus.start_fetch = 1'b1;
        rob_clear       = 1'b1;
        @(negedge clk);
        rob_clear = 1'b0;
        check("fhit no ready", {31'd0, bus.fetch_ready}, 32'd0);
        check("fhit no req", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        check("fhit ready", {31'd0, bus.fetch_ready}, 32'd1);
        check("fhit inst", bus.inst, 32'h0403_0201);
        @(negedge clk);
        bus.start_fetch = 1'b0;
        @(negedge clk);

        // rdy low mid-fill with stray byte strobes.
        bus.pc          = 32'h0000_0030;
        bus.start_fetch = 1'b1;
        @(negedge clk);
        check("stall addr0", bus.mem_addr, 32'h30);
        give_byte(8'hAA);
        check("stall addr1", bus.mem_addr, 32'h31);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_byte_valid = (i % 2 == 0);
            bus.mem_byte       = 8'hFF;
            @(negedge clk);
            check("stall addr hold", bus.mem_addr, 32'h31);
            check("stall req hold", {31'd0, bus.mem_req}, 32'd1);
            check("stall no ready", {31'd0, bus.fetch_ready}, 32'd0);
        end
        bus.mem_byte_valid = 1'b0;
        rdy                = 1'b1;
        give_byte(8'hBB);
        check("resume addr2", bus.mem_addr, 32'h32);
        give_byte(8'hCC);
        check("resume addr3", bus.mem_addr, 32'h33);
        give_byte(8'hDD);
        check("resume ready", {31'd0, bus.fetch_ready}, 32'd1);
        check("resume inst", bus.inst, 32'hDDCC_BBAA);
        check("resume inst_addr", bus.inst_addr, 32'h30);
        check("resume req drop", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        bus.start_fetch = 1'b0;
        @(negedge clk);
        fetch_hit(32'h0000_0030, 32'hDDCC_BBAA, "stall hit");

        // Reset clears every valid bit: a previously cached word misses.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fetch_miss(32'h0000_0010, 32'h0010_0513, 0, "post rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
